// File: rtl/multi_rangefinder.sv
// Multi-channel running min/max tracker: go..finish windows on a channel-tagged sample bus, one shared result port.
// Latency 1 cycle from finish/error to result/err outputs; no backpressure, one channel addressed per cycle.
// Optional min_out/max_out ports when MULTI_RANGEFINDER_MINMAX_EN is defined.
module multi_rangefinder #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 4,
    parameter int CNTW   = 8,
    parameter int SIGNED = 0,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CW-1:0]    in_chan,
    input  logic             in_valid,
    input  logic             go,
    input  logic             finish,
    input  logic [WIDTH-1:0] data_in,
    output logic             range_valid,
    output logic [CW-1:0]    range_chan,
    output logic [WIDTH-1:0] range_out,
    output logic [CNTW-1:0]  count_out,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             err_sticky
`ifdef MULTI_RANGEFINDER_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
`endif
);

    localparam logic [1:0] ERR_GO_RUN   = 2'b01;
    localparam logic [1:0] ERR_FIN_IDLE = 2'b10;
    localparam logic [1:0] ERR_BAD_CHAN = 2'b11;

    logic [NCH-1:0]   run_q;
    logic [WIDTH-1:0] min_q [NCH];
    logic [WIDTH-1:0] max_q [NCH];
    logic [CNTW-1:0]  cnt_q [NCH];

    logic             range_valid_q, err_pulse_q, err_sticky_q;
    logic [CW-1:0]    range_chan_q;
    logic [WIDTH-1:0] range_q, min_out_q, max_out_q;
    logic [CNTW-1:0]  count_q;
    logic [1:0]       err_code_q;

    logic             chan_ok, any_act;
    logic [CW-1:0]    cidx;
    logic             cur_run, run_d, ch_we, res_vld, err_vld;
    logic [WIDTH-1:0] cur_min, cur_max, min_d, max_d;
    logic [CNTW-1:0]  cur_cnt, cnt_d;
    logic [1:0]       err_code_d;

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction

    always_comb begin
        chan_ok    = (32'(in_chan) < 32'(NCH));
        any_act    = go | finish | in_valid;
        cidx       = chan_ok ? in_chan : '0;
        cur_run    = run_q[cidx];
        cur_min    = min_q[cidx];
        cur_max    = max_q[cidx];
        cur_cnt    = cnt_q[cidx];
        run_d      = cur_run;
        min_d      = cur_min;
        max_d      = cur_max;
        cnt_d      = cur_cnt;
        ch_we      = 1'b0;
        res_vld    = 1'b0;
        err_vld    = 1'b0;
        err_code_d = err_code_q;
        if (!chan_ok) begin
            if (any_act) begin
                err_vld    = 1'b1;
                err_code_d = ERR_BAD_CHAN;
            end
        end else if (!cur_run) begin
            if (go) begin
                ch_we   = 1'b1;
                min_d   = data_in;
                max_d   = data_in;
                cnt_d   = CNTW'(1);
                run_d   = !finish;
                res_vld = finish;
            end else if (finish) begin
                err_vld    = 1'b1;
                err_code_d = ERR_FIN_IDLE;
            end
        end else begin
            if (go) begin
                err_vld    = 1'b1;
                err_code_d = ERR_GO_RUN;
            end
            // A go on a running window carries no sample unless it also closes the window.
            if (in_valid && (!go || finish)) begin
                ch_we = 1'b1;
                if (less_than(data_in, cur_min)) min_d = data_in;
                if (less_than(cur_max, data_in)) max_d = data_in;
                if (cur_cnt != {CNTW{1'b1}}) cnt_d = cur_cnt + CNTW'(1);
            end
            if (finish) begin
                ch_we   = 1'b1;
                run_d   = 1'b0;
                res_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                min_q[i] <= '0;
                max_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (ch_we) begin
            run_q[cidx] <= run_d;
            min_q[cidx] <= min_d;
            max_q[cidx] <= max_d;
            cnt_q[cidx] <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            range_valid_q <= 1'b0;
            range_chan_q  <= '0;
            range_q       <= '0;
            count_q       <= '0;
            min_out_q     <= '0;
            max_out_q     <= '0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            range_valid_q <= res_vld;
            err_pulse_q   <= err_vld;
            err_sticky_q  <= err_sticky_q | err_vld;
            if (err_vld) err_code_q <= err_code_d;
            if (res_vld) begin
                range_chan_q <= cidx;
                // max >= min under the active ordering, so the modular difference is exact.
                range_q      <= max_d - min_d;
                count_q      <= cnt_d;
                min_out_q    <= min_d;
                max_out_q    <= max_d;
            end
        end
    end

    assign range_valid = range_valid_q;
    assign range_chan  = range_chan_q;
    assign range_out   = range_q;
    assign count_out   = count_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign err_sticky  = err_sticky_q;

`ifdef MULTI_RANGEFINDER_MINMAX_EN
    assign min_out = min_out_q;
    assign max_out = max_out_q;
`else
    logic unused_minmax;
    assign unused_minmax = ^{min_out_q, max_out_q};
`endif

endmodule

// File: tb/tb_multi_rangefinder.sv
// Bench: unsigned/CNTW=8 and signed/CNTW=4 instances share one stimulus stream, checked against a window-queue model.
module tb_multi_rangefinder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [2:0]  in_chan;
    logic        in_valid, go, finish;
    logic [15:0] data_in;

    logic        rv0, ep0, es0, rv1, ep1, es1;
    logic [2:0]  ch0, ch1;
    logic [15:0] rng0, rng1;
    logic [7:0]  cnt0;
    logic [3:0]  cnt1;
    logic [1:0]  ec0, ec1;
`ifdef MULTI_RANGEFINDER_MINMAX_EN
    logic [15:0] mn0, mx0, mn1, mx1;
`endif

    multi_rangefinder #(.WIDTH(16), .NCH(5), .CNTW(8), .SIGNED(0)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_chan(in_chan), .in_valid(in_valid),
        .go(go), .finish(finish), .data_in(data_in),
        .range_valid(rv0), .range_chan(ch0), .range_out(rng0), .count_out(cnt0),
        .err_pulse(ep0), .err_code(ec0), .err_sticky(es0)
`ifdef MULTI_RANGEFINDER_MINMAX_EN
        , .min_out(mn0), .max_out(mx0)
`endif
    );

    multi_rangefinder #(.WIDTH(16), .NCH(5), .CNTW(4), .SIGNED(1)) u_dut_s (
        .clock(clock), .reset_n(reset_n), .in_chan(in_chan), .in_valid(in_valid),
        .go(go), .finish(finish), .data_in(data_in),
        .range_valid(rv1), .range_chan(ch1), .range_out(rng1), .count_out(cnt1),
        .err_pulse(ep1), .err_code(ec1), .err_sticky(es1)
`ifdef MULTI_RANGEFINDER_MINMAX_EN
        , .min_out(mn1), .max_out(mx1)
`endif
    );

    // Reference model: each open window is just the list of its samples.
    bit          run_m [5];
    logic [15:0] win [5][$];
    bit          e_rv, e_ep, e_es;
    logic [2:0]  e_ch;
    logic [1:0]  e_ec;
    logic [15:0] e_rng [2];
    logic [15:0] e_mn [2];
    logic [15:0] e_mx [2];
    int          e_cnt [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            run_m[i] = 0;
            win[i].delete();
        end
        e_rv = 0; e_ep = 0; e_es = 0; e_ch = 0; e_ec = 0;
        for (int k = 0; k < 2; k++) begin
            e_rng[k] = 0; e_mn[k] = 0; e_mx[k] = 0; e_cnt[k] = 0;
        end
    endtask

    task automatic emit_result(input int c);
        int mn, mx, v, sat;
        e_rv = 1;
        e_ch = 3'(c);
        for (int k = 0; k < 2; k++) begin
            sat = (k == 0) ? 255 : 15;
            mn = 0; mx = 0;
            for (int j = 0; j < win[c].size(); j++) begin
                v = (k == 0) ? int'(win[c][j]) : int'($signed(win[c][j]));
                if (j == 0 || v < mn) mn = v;
                if (j == 0 || v > mx) mx = v;
            end
            e_rng[k] = 16'(mx - mn);
            e_mn[k]  = 16'(mn);
            e_mx[k]  = 16'(mx);
            e_cnt[k] = (win[c].size() > sat) ? sat : win[c].size();
        end
        win[c].delete();
    endtask

    task automatic model_step(input bit g, input bit f, input bit v, input int c, input logic [15:0] d);
        bit err;
        logic [1:0] code;
        err = 0; code = 0;
        e_rv = 0;
        if (c >= 5) begin
            if (g || f || v) begin err = 1; code = 2'b11; end
        end else if (!run_m[c]) begin
            if (g) begin
                win[c].delete();
                win[c].push_back(d);
                if (f) emit_result(c);
                else   run_m[c] = 1;
            end else if (f) begin
                err = 1; code = 2'b10;
            end
        end else begin
            if (g) begin err = 1; code = 2'b01; end
            if (v && (!g || f)) win[c].push_back(d);
            if (f) begin
                emit_result(c);
                run_m[c] = 0;
            end
        end
        e_ep = err;
        if (err) e_ec = code;
        e_es = e_es | err;
    endtask

    task automatic check_all();
        chk("rv0", rv0, e_rv);      chk("rv1", rv1, e_rv);
        chk("chan0", ch0, e_ch);    chk("chan1", ch1, e_ch);
        chk("range0", rng0, e_rng[0]); chk("range1", rng1, e_rng[1]);
        chk("count0", cnt0, e_cnt[0]); chk("count1", cnt1, e_cnt[1]);
        chk("errp0", ep0, e_ep);    chk("errp1", ep1, e_ep);
        chk("errc0", ec0, e_ec);    chk("errc1", ec1, e_ec);
        chk("errs0", es0, e_es);    chk("errs1", es1, e_es);
`ifdef MULTI_RANGEFINDER_MINMAX_EN
        chk("min0", mn0, e_mn[0]);  chk("min1", mn1, e_mn[1]);
        chk("max0", mx0, e_mx[0]);  chk("max1", mx1, e_mx[1]);
`endif
    endtask

    // Called at a falling edge: drive, advance the model, check after the next rising edge.
    task automatic step(input bit g, input bit f, input bit v, input int c, input logic [15:0] d);
        go = g; finish = f; in_valid = v; in_chan = 3'(c); data_in = d;
        model_step(g, f, v, c, d);
        @(negedge clock);
        check_all();
    endtask

    task automatic idle_inputs();
        go = 0; finish = 0; in_valid = 0; in_chan = 0; data_in = 0;
    endtask

    initial begin
        logic [15:0] d;
        int c, g, f, v;
        reset_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clock);
        check_all();
        @(negedge clock);
        reset_n = 1;

        // Basic unsigned window on chan0
        step(1, 0, 0, 0, 16'h0010);
        step(0, 0, 1, 0, 16'h0005);
        step(0, 0, 1, 0, 16'h0040);
        step(0, 1, 1, 0, 16'h0020);
        chk("tp1_range", rng0, 16'h003B);
        chk("tp1_count", cnt0, 4);

        // Interleaved windows on chan1/chan2
        step(1, 0, 0, 1, 16'd100);
        step(1, 0, 0, 2, 16'd7);
        step(0, 0, 1, 1, 16'd150);
        step(0, 0, 1, 2, 16'd3);
        step(0, 1, 0, 1, 16'd0);
        chk("tp2_range1", rng0, 50);
        chk("tp2_chan1", ch0, 1);
        step(0, 1, 0, 2, 16'd0);
        chk("tp2_range2", rng0, 4);
        chk("tp2_count2", cnt0, 2);

        // Signed ordering
        step(1, 0, 0, 3, 16'hFFF6);
        step(0, 0, 1, 3, 16'h0014);
        step(0, 1, 0, 3, 16'h0000);
        chk("tp3_srange", rng1, 30);
`ifdef MULTI_RANGEFINDER_MINMAX_EN
        chk("tp3_smin", mn1, 16'hFFF6);
        chk("tp3_smax", mx1, 16'h0014);
`endif

        // Protocol errors
        step(0, 1, 0, 3, 16'h0000);
        chk("tp4_fin_idle", ec0, 2'b10);
        step(1, 0, 0, 0, 16'h0001);
        step(1, 0, 1, 0, 16'h0009);
        chk("tp4_go_run", ec0, 2'b01);
        step(0, 0, 1, 0, 16'h0002);
        step(0, 1, 0, 0, 16'h0000);
        chk("tp4_count", cnt0, 2);
        step(0, 0, 1, 5, 16'h0000);
        chk("tp4_bad_chan", ec0, 2'b11);
        chk("tp4_sticky", es0, 1);

        // Count saturation (signed instance has a 4-bit count)
        step(1, 0, 0, 4, 16'h0000);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 4, 16'($urandom));
        step(0, 1, 0, 4, 16'h0000);
        chk("tp5_sat", cnt1, 15);

        // go+finish on an idle channel
        step(1, 1, 0, 0, 16'h1234);
        chk("tp6_range", rng0, 0);
        chk("tp6_count", cnt0, 1);

        // Reset in the middle of a window
        step(1, 0, 0, 2, 16'd50);
        step(0, 0, 1, 2, 16'd60);
        idle_inputs();
        reset_n = 0;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        check_all();
        reset_n = 1;
        step(0, 1, 0, 2, 16'h0000);
        chk("tp7_err", ec0, 2'b10);
        chk("tp7_novalid", rv0, 0);

        // Random traffic including out-of-range channels
        for (int i = 0; i < 600; i++) begin
            c = $urandom_range(0, 6);
            g = ($urandom_range(0, 99) < 15) ? 1 : 0;
            f = ($urandom_range(0, 99) < 15) ? 1 : 0;
            v = ($urandom_range(0, 99) < 70) ? 1 : 0;
            case ($urandom_range(0, 5))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                2:       d = 16'h8000;
                3:       d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            step(g[0], f[0], v[0], c, d);
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_rangefinder.md
Name:
multi_rangefinder

Overview:
- Multi-channel, parametrised successor to the single-channel range tracker.
- Tracks running min/max per channel over go..finish windows on a shared, channel-tagged sample bus.
- Reports range (max-min), sample count and protocol errors for each completed window.
- Sits between the chip I/O sample interface and the output mux; one result port is shared by all channels.

Parameters:
- WIDTH, 16, sample and range width in bits
- NCH, 4, number of independent channels (1..16)
- CNTW, 8, sample-count width in bits; the count saturates
- SIGNED, 0, 1 = samples compared as two's complement; 0 = unsigned

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_chan  in  max(1,$clog2(NCH))  channel tag for go/finish/in_valid this cycle
- in_valid  in  1  data_in is a sample for in_chan
- go  in  1  open a window on in_chan; data_in is its first sample
- finish  in  1  close the window on in_chan
- data_in  in  WIDTH  sample value
- range_valid  out  1  one-cycle pulse: result fields valid
- range_chan  out  max(1,$clog2(NCH))  channel of the result
- range_out  out  WIDTH  max-min as unsigned WIDTH bits
- count_out  out  CNTW  samples in the window (saturating)
- err_pulse  out  1  one-cycle pulse: protocol error this cycle
- err_code  out  2  01 go-while-running, 10 finish-while-idle, 11 bad channel; held until the next error
- err_sticky  out  1  set on any error; cleared only by reset

Behaviour:
- Reset (async, reset_n=0):
  - all channels go to IDLE.
  - every output is 0, and per-channel min/max/count are 0.
- State per channel: IDLE, RUN. Only the channel addressed by in_chan can change state in a cycle.
- go, IDLE:
  - min=max=data_in and count=1; in_valid is ignored.
  - Next state RUN.
- in_valid, RUN, no go/finish:
  - min=min(min,data_in), max=max(max,data_in).
  - count+1, saturating at 2^CNTW-1.
- Comparison: signed when SIGNED=1, unsigned otherwise.
- Range: range_out = max-min computed in WIDTH+1 bits with the low WIDTH bits kept; the result is exact in both modes.
- finish, RUN:
  - A sample in the same cycle (in_valid=1) is folded in first.
  - Next cycle: range_valid=1, with range_chan, range_out and count_out.
  - Next state IDLE.
- go+finish same cycle, IDLE:
  - The window holds one sample.
  - Next cycle: range_valid=1, range_out=0, count_out=1.
  - Channel ends IDLE.
- go, RUN: error 01; the sample is not folded in and the channel stays RUN.
  - If finish is also set, the finish proceeds as above, with in_valid gating the sample.
- finish, IDLE, no go: error 10; no result is produced.
- in_chan >= NCH with go, finish or in_valid: error 11; no channel state changes.
- Errors: err_pulse, err_code and err_sticky update on the cycle after the offending input, i.e. the same latency as the result.
- Result registers: range_out, count_out and range_chan hold their last value while range_valid=0.
  - At most one result per cycle, because only one channel is addressed per cycle.
- Latency:
  - Result: exactly 1 cycle after finish.
  - Throughput: a new window may open on a channel the cycle after its finish; the channel is already IDLE.
- Reset mid-window: the window is discarded and no result is produced.

Optional Feature:
- Macro: MULTI_RANGEFINDER_MINMAX_EN.
- Defined:
  - Adds outputs min_out and max_out (WIDTH each), registered with the result and valid with range_valid.
  - Both reset to 0.
- Undefined: the ports are absent and range_out alone is reported. Core behaviour is identical.

Test Plan:
- WIDTH=16, SIGNED=0, chan0:
  - Stimulus: go data=0x0010, samples 0x0005 and 0x0040, finish with data 0x0020 and in_valid=1.
  - Required next cycle: range_valid=1, range_chan=0, range_out=0x003B, count_out=4.
- Interleaved windows:
  - Stimulus: chan1 go 100, chan2 go 7, chan1 sample 150, chan2 sample 3, chan1 finish, chan2 finish.
  - Required: chan1 result 50/count 2, then chan2 result 4/count 2 on consecutive cycles.
- SIGNED=1:
  - Stimulus: go 0xFFF6 (-10), sample 0x0014 (20), finish.
  - Required: range_out=30; with the macro, min_out=0xFFF6 and max_out=0x0014.
- Errors:
  - finish on idle chan3 -> err_pulse, err_code=10, no range_valid.
  - go on running chan0 -> err_code=01, window continues and its count is unchanged.
  - in_chan=NCH -> err_code=11.
  - err_sticky stays 1 after all three.
- Saturation, CNTW=4: go then 20 samples, finish -> count_out=15.
- Boundary: go+finish same cycle on idle chan0 -> range_out=0, count_out=1.
- Reset:
  - Stimulus: reset_n low mid-window, release, then finish on that channel.
  - Required: err_code=10, all outputs 0 during reset.
